// File: rtl/rot_square_ctrl_if.sv
// Register write/readback bus for the rotating-square controller.
// The board top (or bench) is the master; the controller is the slave.
interface rot_square_ctrl_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_wdata;
  logic [23:0] cfg_rdata;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/rot_square_ctrl.sv
// Position sequencer and digit driver for the six-digit rotating square.
// Period/control registers, run/stop, single-step, one-lap mode, blanking.
module rot_square_ctrl #(
  parameter logic [23:0] DVSR_DEFAULT = 24'd12500000,
  parameter logic        RUN_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  rot_square_ctrl_if.slave  cfg,
  output logic [3:0]        pos,
  output logic              step_pulse,
  output logic              lap_done,
  output logic [7:0]        bcd0,
  output logic [7:0]        bcd1,
  output logic [7:0]        bcd2,
  output logic [7:0]        bcd3,
  output logic [7:0]        bcd4,
  output logic [7:0]        bcd5
);

  localparam logic [7:0] SEG_UPPER = 8'b10011100;
  localparam logic [7:0] SEG_LOWER = 8'b10100011;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [23:0] period_q, period_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  pos_q, pos_d;
  logic        run_q, run_d;
  logic        dir_q, dir_d;
  logic        oneshot_q, oneshot_d;
  logic        disp_en_q, disp_en_d;
  logic        step_pulse_q, lap_done_q;

  logic        wr_period, wr_ctrl, wr_step;
  logic        do_step, do_wrap;
  logic [47:0] segs;

  // Out-of-range positions recover to 0 on the next step.
  function automatic logic [3:0] next_pos(input logic [3:0] p, input logic rev);
    if (p > 4'd11) begin
      return 4'd0;
    end else if (rev) begin
      return (p == 4'd0) ? 4'd11 : p - 4'd1;
    end else begin
      return (p == 4'd11) ? 4'd0 : p + 4'd1;
    end
  endfunction

  function automatic logic is_wrap(input logic [3:0] p, input logic rev);
    return rev ? (p == 4'd0) : (p == 4'd11);
  endfunction

  assign wr_period = cfg.cfg_we && (cfg.cfg_addr == 2'd0);
  assign wr_ctrl   = cfg.cfg_we && (cfg.cfg_addr == 2'd1);
  assign wr_step   = cfg.cfg_we && (cfg.cfg_addr == 2'd2);

  // A register write pre-empts a counter step; step commands only act while stopped.
  always_comb begin
    if (run_q) begin
      do_step = (cnt_q == period_q) && !wr_period && !wr_ctrl;
    end else begin
      do_step = wr_step;
    end
    do_wrap = do_step && is_wrap(pos_q, dir_q);
  end

  always_comb begin
    period_d  = period_q;
    run_d     = run_q;
    dir_d     = dir_q;
    oneshot_d = oneshot_q;
    disp_en_d = disp_en_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    if (wr_period) begin
      period_d = cfg.cfg_wdata;
    end else begin
      period_d = period_q;
    end
    if (wr_ctrl) begin
      run_d     = cfg.cfg_wdata[0];
      dir_d     = cfg.cfg_wdata[1];
      oneshot_d = cfg.cfg_wdata[2];
      disp_en_d = cfg.cfg_wdata[3];
    end else if (do_wrap && oneshot_q) begin
      run_d = 1'b0;
    end else begin
      run_d = run_q;
    end
    if (wr_period || wr_ctrl || !run_q || (cnt_q == period_q)) begin
      cnt_d = 24'd0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
    if (do_step) begin
      pos_d = next_pos(pos_q, dir_q);
    end else begin
      pos_d = pos_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      period_q     <= DVSR_DEFAULT;
      run_q        <= RUN_AT_RESET;
      dir_q        <= 1'b0;
      oneshot_q    <= 1'b0;
      disp_en_q    <= 1'b1;
      cnt_q        <= 24'd0;
      pos_q        <= 4'd0;
      step_pulse_q <= 1'b0;
      lap_done_q   <= 1'b0;
    end else begin
      period_q     <= period_d;
      run_q        <= run_d;
      dir_q        <= dir_d;
      oneshot_q    <= oneshot_d;
      disp_en_q    <= disp_en_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      step_pulse_q <= do_step;
      lap_done_q   <= do_wrap;
    end
  end

  always_comb begin
    case (cfg.cfg_addr)
      2'd0:    cfg.cfg_rdata = period_q;
      2'd1:    cfg.cfg_rdata = {20'd0, disp_en_q, oneshot_q, dir_q, run_q};
      2'd2:    cfg.cfg_rdata = 24'd0;
      2'd3:    cfg.cfg_rdata = {20'd0, pos_q};
      default: cfg.cfg_rdata = 24'd0;
    endcase
  end

  // Upper square walks bcd5..bcd0 for pos 0..5, lower square bcd0..bcd5 for pos 6..11.
  always_comb begin
    segs = {6{SEG_BLANK}};
    for (int i = 0; i < 6; i++) begin
      if (disp_en_q && (pos_q == 4'(5 - i))) begin
        segs[8*i +: 8] = SEG_UPPER;
      end else if (disp_en_q && (pos_q == 4'(6 + i))) begin
        segs[8*i +: 8] = SEG_LOWER;
      end else begin
        segs[8*i +: 8] = SEG_BLANK;
      end
    end
  end

  assign pos        = pos_q;
  assign step_pulse = step_pulse_q;
  assign lap_done   = lap_done_q;
  assign bcd0       = segs[7:0];
  assign bcd1       = segs[15:8];
  assign bcd2       = segs[23:16];
  assign bcd3       = segs[31:24];
  assign bcd4       = segs[39:32];
  assign bcd5       = segs[47:40];

endmodule

// File: tb/tb_rot_square_ctrl.sv
// Directed, table-driven bench for rot_square_ctrl with a short period (3).
module tb_rot_square_ctrl;

  logic       clk;
  logic       clr;
  logic [3:0] pos;
  logic       step_pulse, lap_done;
  logic [7:0] bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;
  logic [47:0] bcd_all;

  rot_square_ctrl_if bus ();

  rot_square_ctrl #(.DVSR_DEFAULT(24'd3), .RUN_AT_RESET(1'b1)) dut (
    .clk(clk), .clr(clr), .cfg(bus), .pos(pos),
    .step_pulse(step_pulse), .lap_done(lap_done),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4), .bcd5(bcd5)
  );

  assign bcd_all = {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pos;
    logic        lap;
    logic [47:0] bcd;
  } vec_t;

  vec_t tbl [12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the following rising edge.
  task automatic cfg_write(input logic [1:0] a, input logic [23:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
  endtask

  task automatic wait_step(output int n);
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = step_pulse;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL step_timeout: got no step_pulse after %0d cycles expected one", n);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [23:0] exp, input string nm);
    bus.cfg_addr = a;
    #1;
    chk(nm, {24'd0, bus.cfg_rdata}, {24'd0, exp});
  endtask

  initial begin
    int n;
    int pulses, laps;

    tbl[0]  = '{4'd1,  1'b0, 48'hFF9CFFFFFFFF};
    tbl[1]  = '{4'd2,  1'b0, 48'hFFFF9CFFFFFF};
    tbl[2]  = '{4'd3,  1'b0, 48'hFFFFFF9CFFFF};
    tbl[3]  = '{4'd4,  1'b0, 48'hFFFFFFFF9CFF};
    tbl[4]  = '{4'd5,  1'b0, 48'hFFFFFFFFFF9C};
    tbl[5]  = '{4'd6,  1'b0, 48'hFFFFFFFFFFA3};
    tbl[6]  = '{4'd7,  1'b0, 48'hFFFFFFFFA3FF};
    tbl[7]  = '{4'd8,  1'b0, 48'hFFFFFFA3FFFF};
    tbl[8]  = '{4'd9,  1'b0, 48'hFFFFA3FFFFFF};
    tbl[9]  = '{4'd10, 1'b0, 48'hFFA3FFFFFFFF};
    tbl[10] = '{4'd11, 1'b0, 48'hA3FFFFFFFFFF};
    tbl[11] = '{4'd0,  1'b1, 48'h9CFFFFFFFFFF};

    clr = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = 2'd0;
    bus.cfg_wdata = 24'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_pos", {44'd0, pos}, 48'd0);
    chk("reset_bcd", bcd_all, 48'h9CFFFFFFFFFF);
    chk("reset_pulses", {46'd0, step_pulse, lap_done}, 48'd0);
    rd(2'd0, 24'd3, "reset_period");
    rd(2'd1, 24'h9, "reset_ctrl");
    rd(2'd3, 24'd0, "reset_status");
    bus.cfg_addr = 2'd0;
    @(negedge clk);
    clr = 1'b0;

    // One full forward lap from the table.
    for (int i = 0; i < 12; i++) begin
      wait_step(n);
      chk("lap_interval", 48'(n), 48'd4);
      chk("lap_pos", {44'd0, pos}, {44'd0, tbl[i].pos});
      chk("lap_bcd", bcd_all, tbl[i].bcd);
      chk("lap_done", {47'd0, lap_done}, {47'd0, tbl[i].lap});
    end
    @(negedge clk);
    chk("lap_done_one_cycle", {46'd0, step_pulse, lap_done}, 48'd0);

    // Reverse from pos 2: 1, 0, 11 with a wrap on the last.
    wait_step(n);
    wait_step(n);
    chk("pre_rev_pos", {44'd0, pos}, 48'd2);
    cfg_write(2'd1, 24'hB);
    rd(2'd1, 24'hB, "rev_ctrl_read");
    bus.cfg_addr = 2'd0;
    for (int i = 0; i < 3; i++) begin
      wait_step(n);
      chk("rev_interval", 48'(n), 48'd4);
      chk("rev_pos", {44'd0, pos}, (i == 0) ? 48'd1 : (i == 1) ? 48'd0 : 48'd11);
      chk("rev_lap", {47'd0, lap_done}, (i == 2) ? 48'd1 : 48'd0);
    end

    // Stopped: three single steps, forward, from 11.
    cfg_write(2'd1, 24'h0);
    chk("stop_blank", bcd_all, 48'hFFFFFFFFFFFF);
    rd(2'd1, 24'h0, "stop_ctrl_read");
    for (int k = 0; k < 3; k++) begin
      cfg_write(2'd2, 24'd0);
      chk("cmd_pulse", {47'd0, step_pulse}, 48'd1);
      chk("cmd_pos", {44'd0, pos}, 48'(k));
      chk("cmd_lap", {47'd0, lap_done}, (k == 0) ? 48'd1 : 48'd0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("stop_hold_pos", {44'd0, pos}, 48'd2);
    chk("stop_hold_pulse", {47'd0, step_pulse}, 48'd0);
    cfg_write(2'd3, 24'h5);
    rd(2'd3, 24'd2, "status_write_ignored");
    bus.cfg_addr = 2'd0;

    // Running: step commands add nothing, even when coincident with a counter step.
    cfg_write(2'd1, 24'h9);
    cfg_write(2'd2, 24'd0);
    chk("run_cmd_ignored_pulse", {47'd0, step_pulse}, 48'd0);
    chk("run_cmd_ignored_pos", {44'd0, pos}, 48'd2);
    wait_step(n);
    chk("run_cmd_interval", 48'(n), 48'd3);
    chk("run_cmd_pos", {44'd0, pos}, 48'd3);
    repeat (3) @(negedge clk);
    cfg_write(2'd2, 24'd0);
    chk("coinc_pulse", {47'd0, step_pulse}, 48'd1);
    chk("coinc_pos", {44'd0, pos}, 48'd4);
    @(negedge clk);
    chk("coinc_single_pulse", {47'd0, step_pulse}, 48'd0);
    chk("coinc_single_pos", {44'd0, pos}, 48'd4);

    // One-lap mode with period 0: a step per clock until the wrap from 11.
    cfg_write(2'd0, 24'd0);
    cfg_write(2'd1, 24'hD);
    chk("oneshot_write_no_step", {47'd0, step_pulse}, 48'd0);
    pulses = 0;
    laps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
      if (lap_done) laps++;
    end
    chk("oneshot_steps", 48'(pulses), 48'd8);
    chk("oneshot_laps", 48'(laps), 48'd1);
    chk("oneshot_pos", {44'd0, pos}, 48'd0);
    rd(2'd1, 24'hC, "oneshot_run_cleared");
    bus.cfg_addr = 2'd0;

    // Period write coinciding with cnt == period suppresses that step.
    cfg_write(2'd0, 24'd3);
    cfg_write(2'd1, 24'h9);
    wait_step(n);
    chk("p3_interval", 48'(n), 48'd4);
    chk("p3_pos", {44'd0, pos}, 48'd1);
    repeat (3) @(negedge clk);
    cfg_write(2'd0, 24'd5);
    chk("pwrite_no_step", {47'd0, step_pulse}, 48'd0);
    chk("pwrite_pos", {44'd0, pos}, 48'd1);
    wait_step(n);
    chk("p5_interval", 48'(n), 48'd6);
    chk("p5_pos", {44'd0, pos}, 48'd2);
    cfg_write(2'd1, 24'h1);
    chk("blank_bcd", bcd_all, 48'hFFFFFFFFFFFF);
    wait_step(n);
    chk("blank_interval", 48'(n), 48'd6);
    chk("blank_pos", {44'd0, pos}, 48'd3);
    chk("blank_bcd_after", bcd_all, 48'hFFFFFFFFFFFF);

    // Asynchronous reset between edges.
    repeat (2) @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("async_pos", {44'd0, pos}, 48'd0);
    chk("async_bcd", bcd_all, 48'h9CFFFFFFFFFF);
    chk("async_pulses", {46'd0, step_pulse, lap_done}, 48'd0);
    rd(2'd0, 24'd3, "async_period");
    rd(2'd1, 24'h9, "async_ctrl");
    bus.cfg_addr = 2'd0;
    @(negedge clk);
    clr = 1'b0;
    wait_step(n);
    chk("post_rst_interval", 48'(n), 48'd4);
    chk("post_rst_pos", {44'd0, pos}, 48'd1);
    wait_step(n);
    chk("post_rst_interval2", 48'(n), 48'd4);
    chk("post_rst_pos2", {44'd0, pos}, 48'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
